psram_frame_arbiter: RTL

PSRAM_FRAME_ARBITER -- requirements
Module: psram_frame_arbiter

---
 rtl/psram_frame_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/psram_frame_arbiter.sv
// PSRAM frame arbiter: shares one PSRAM command port between a camera write
// stream and a VGA read stream, double-buffering frames across two banks.
//
// Handshake: cmd_valid/cmd_we/cmd_addr are held stable while cmd_valid is high;
// a command is accepted on a clock edge where cmd_valid & cmd_ready are both 1,
// and cmd_valid drops on the following cycle. cmd_ready has no effect while
// cmd_valid is 0. After acceptance the arbiter waits for a burst_done pulse.
module psram_frame_arbiter #(
    parameter int BURST_LEN     = 64,
    parameter int FRAME_WORDS   = 786432,
    parameter int RD_FIFO_DEPTH = 512
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_calib,
    input  logic        wr_load,
    input  logic        rd_load,
    input  logic [9:0]  wr_fifo_cnt,
    input  logic [9:0]  rd_fifo_cnt,
    input  logic        cmd_ready,
    input  logic        burst_done,
    output logic        cmd_valid,
    output logic        cmd_we,
    output logic [20:0] cmd_addr,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic        frame_swap,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_CMD  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [9:0]  L_BURST_CNT = 10'(BURST_LEN);
    localparam logic [9:0]  L_RD_THRESH = 10'(RD_FIFO_DEPTH - BURST_LEN);
    localparam logic [20:0] L_BURST_OFF = 21'(BURST_LEN);
    localparam logic [20:0] L_FRAME_END = 21'(FRAME_WORDS);

    state_t      r_state;
    logic        r_cmd_valid;
    logic        r_cmd_we;
    logic [20:0] r_cmd_addr;
    logic        r_busy;
    logic        r_last_wr;
    logic [19:0] r_wr_off;
    logic [19:0] r_rd_off;
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic        r_frame_swap;

    logic        w_wr_req;
    logic        w_rd_req;
    logic        w_rd_urgent;
    logic        w_grant_wr;
    logic        w_accept;
    logic        w_wr_adv;
    logic        w_rd_adv;
    logic [20:0] w_wr_sum;
    logic [20:0] w_rd_sum;
    logic        w_wr_wrap;
    logic        w_rd_wrap;
    logic        w_wr_bank_nxt;

    assign w_wr_req    = (wr_fifo_cnt >= L_BURST_CNT);
    assign w_rd_req    = (rd_fifo_cnt <= L_RD_THRESH);
    assign w_rd_urgent = (rd_fifo_cnt < L_BURST_CNT);
    // Urgent read first; on contention alternate against the last grant.
    assign w_grant_wr  = !w_rd_urgent && w_wr_req && (!w_rd_req || !r_last_wr);

    // A calibration drop in the same cycle as cmd_ready cancels the handshake.
    assign w_accept = (r_state == S_CMD) && r_cmd_valid && cmd_ready && init_calib;
    // A load in the same cycle as an advance wins and suppresses the wrap.
    assign w_wr_adv = w_accept && r_cmd_we && !wr_load;
    assign w_rd_adv = w_accept && !r_cmd_we && !rd_load;

    assign w_wr_sum  = {1'b0, r_wr_off} + L_BURST_OFF;
    assign w_rd_sum  = {1'b0, r_rd_off} + L_BURST_OFF;
    assign w_wr_wrap = (w_wr_sum == L_FRAME_END);
    assign w_rd_wrap = (w_rd_sum == L_FRAME_END);
    assign w_wr_bank_nxt = r_wr_bank ^ (w_wr_adv && w_wr_wrap);

    // Command FSM: arbitration, registered command outputs and busy flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= 21'd0;
            r_busy      <= 1'b0;
            r_last_wr   <= 1'b0;
        end else if (!init_calib) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_wr_req || w_rd_req) begin
                        r_state     <= S_CMD;
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= w_grant_wr;
                        r_cmd_addr  <= w_grant_wr ? {r_wr_bank, r_wr_off}
                                                  : {r_rd_bank, r_rd_off};
                        r_last_wr   <= w_grant_wr;
                        r_busy      <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (r_cmd_valid && cmd_ready) begin
                        r_state     <= S_WAIT;
                        r_cmd_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (burst_done) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Frame offsets and banks: advance on acceptance, wrap at frame end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_off     <= 20'd0;
            r_rd_off     <= 20'd0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_frame_swap <= 1'b0;
        end else begin
            r_frame_swap <= w_wr_adv && w_wr_wrap;
            r_wr_bank    <= w_wr_bank_nxt;
            if (wr_load) begin
                r_wr_off <= 20'd0;
            end else if (w_wr_adv) begin
                r_wr_off <= w_wr_wrap ? 20'd0 : w_wr_sum[19:0];
            end
            if (rd_load) begin
                r_rd_off <= 20'd0;
            end else if (w_rd_adv) begin
                r_rd_off <= w_rd_wrap ? 20'd0 : w_rd_sum[19:0];
            end
            // Reader follows the most recently completed write frame.
            if (w_rd_adv && w_rd_wrap) begin
                r_rd_bank <= ~w_wr_bank_nxt;
            end
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_we     = r_cmd_we;
    assign cmd_addr   = r_cmd_addr;
    assign wr_bank    = r_wr_bank;
    assign rd_bank    = r_rd_bank;
    assign frame_swap = r_frame_swap;
    assign busy       = r_busy;
    assign state_dbg  = r_state;

endmodule
